// File: rtl/pipe_ctrl_gen_if.sv
// pipe_ctrl_gen_if: hazard-controller <-> datapath signal bundle.
// master = controller side (drives control codes), slave = datapath side.
interface pipe_ctrl_gen_if #(
    parameter int unsigned STAGES = 5,
    parameter int unsigned NINT   = 3,
    parameter int unsigned CW     = (NINT > 1) ? $clog2(NINT) : 1
);
    logic                      pval;
    logic [STAGES-1:0]         stage_busy;
    logic [1:0]                jmp;
    logic [NINT-1:0]           intp;
    logic [2*(STAGES-1)-1:0]   ctr;
    logic [1:0]                jmp_type;
    logic [CW-1:0]             int_cause;
    logic [15:0]               stall_cnt;
    logic [15:0]               flush_cnt;

    modport master (
        input  pval, stage_busy, jmp, intp,
        output ctr, jmp_type, int_cause, stall_cnt, flush_cnt
    );

    modport slave (
        output pval, stage_busy, jmp, intp,
        input  ctr, jmp_type, int_cause, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_ctrl_gen.sv
// pipe_ctrl_gen: parametrised pipeline hazard controller.
// Emits a 2-bit code per inter-stage register (LOAD/BUBBLE/HOLD/FLUSH), resolves stalls,
// jump redirects and interrupts via a RUN -> DRAIN -> FLUSH sequence. All state moves on
// the falling edge so codes are ready for the datapath's next rising edge.
// Optional perf counters are built only when PIPE_CTRL_PERF_EN is defined; otherwise
// stall_cnt/flush_cnt are tied to 0.
module pipe_ctrl_gen #(
    parameter int unsigned STAGES    = 5,
    parameter int unsigned JMP_STAGE = 2,
    parameter int unsigned NINT      = 3,
    parameter int unsigned CW        = (NINT > 1) ? $clog2(NINT) : 1
) (
    input logic             clk,
    input logic             rst,
    pipe_ctrl_gen_if.master bus
);
    localparam int R = int'(STAGES) - 1;

    localparam logic [1:0] CtrLoad   = 2'b00;
    localparam logic [1:0] CtrBubble = 2'b01;
    localparam logic [1:0] CtrHold   = 2'b10;
    localparam logic [1:0] CtrFlush  = 2'b11;

    localparam logic [1:0] StRun   = 2'd0;
    localparam logic [1:0] StDrain = 2'd1;
    localparam logic [1:0] StFlush = 2'd2;

    logic [1:0]     state_q, state_d;
    logic [CW-1:0]  cause_q, cause_d;
    logic [2*R-1:0] ctr_q, ctr_d;
    logic [1:0]     jmp_type_q, jmp_type_d;
    logic [CW-1:0]  int_cause_q, int_cause_d;

    int             stall_k;
    logic           busy_any;
    logic           int_any;
    logic [CW-1:0]  int_idx;
    logic [2*R-1:0] stall_pat;
    logic [2*R-1:0] jmp_pat;

    // Locate the oldest busy stage and the deepest (oldest) interrupt source.
    always_comb begin
        stall_k = -1;
        for (int s = 0; s < int'(STAGES); s++) begin
            if (bus.stage_busy[s]) stall_k = s;
        end
        busy_any = |bus.stage_busy;
        int_any  = |bus.intp;
        int_idx  = '0;
        for (int n = 0; n < int'(NINT); n++) begin
            if (bus.intp[n]) int_idx = CW'(n);
        end
    end

    // Stall and jump code patterns; younger regs hold, the busy one bubbles, older ones drain.
    always_comb begin
        stall_pat = '0;
        jmp_pat   = '0;
        for (int i = 0; i < R; i++) begin
            if (i < stall_k) begin
                stall_pat[2*i +: 2] = CtrHold;
            end else if (i == stall_k) begin
                stall_pat[2*i +: 2] = CtrBubble;
            end else begin
                stall_pat[2*i +: 2] = CtrLoad;
            end
            jmp_pat[2*i +: 2] = (i < int'(JMP_STAGE)) ? CtrFlush : CtrLoad;
        end
    end

    // Next-state and next-output decode with RUN-state event priority.
    always_comb begin
        state_d     = state_q;
        cause_d     = cause_q;
        ctr_d       = {R{CtrLoad}};
        jmp_type_d  = 2'b00;
        int_cause_d = int_cause_q;
        unique case (state_q)
            StRun: begin
                if (int_any) begin
                    cause_d = int_idx;
                    ctr_d   = {R{CtrHold}};
                    state_d = busy_any ? StDrain : StFlush;
                end else if (stall_k > int'(JMP_STAGE)) begin
                    // Jump stage is held, so its jmp is re-presented next cycle.
                    ctr_d = stall_pat;
                end else if (bus.jmp[0]) begin
                    // Any stall at or below the jump stage is younger and gets flushed.
                    ctr_d      = jmp_pat;
                    jmp_type_d = {~bus.jmp[1], bus.jmp[1]};
                end else if (busy_any) begin
                    ctr_d = stall_pat;
                end else if (!bus.pval) begin
                    ctr_d[1:0] = CtrBubble;
                end
            end
            StDrain: begin
                ctr_d = {R{CtrHold}};
                if (!busy_any) state_d = StFlush;
            end
            StFlush: begin
                ctr_d       = {R{CtrFlush}};
                jmp_type_d  = 2'b11;
                int_cause_d = cause_q;
                state_d     = StRun;
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    // Falling-edge state and output registers with synchronous reset.
    always_ff @(negedge clk) begin
        if (rst) begin
            state_q     <= StRun;
            cause_q     <= '0;
            ctr_q       <= '0;
            jmp_type_q  <= 2'b00;
            int_cause_q <= '0;
        end else begin
            state_q     <= state_d;
            cause_q     <= cause_d;
            ctr_q       <= ctr_d;
            jmp_type_q  <= jmp_type_d;
            int_cause_q <= int_cause_d;
        end
    end

    assign bus.ctr       = ctr_q;
    assign bus.jmp_type  = jmp_type_q;
    assign bus.int_cause = int_cause_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;
    logic        hold_any;
    logic        flush_evt;

    // Saturating counters: any HOLD code issued, and any redirect (jump or vector).
    always_comb begin
        hold_any = 1'b0;
        for (int i = 0; i < R; i++) begin
            if (ctr_d[2*i +: 2] == CtrHold) hold_any = 1'b1;
        end
        flush_evt   = (jmp_type_d != 2'b00);
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (hold_any && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
        if (flush_evt && (flush_cnt_q != 16'hFFFF)) flush_cnt_d = flush_cnt_q + 16'd1;
    end

    // Counter registers, cleared by reset.
    always_ff @(negedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;
`else
    assign bus.stall_cnt = 16'd0;
    assign bus.flush_cnt = 16'd0;
`endif
endmodule

// File: doc/pipe_ctrl_gen.md
# pipe_ctrl_gen

Parametrised pipeline hazard controller: the successor to the fixed five-stage IF/ID/EX/MEM/WB controller. It drives one 2-bit control code per inter-stage register for an arbitrary stage count. It resolves multi-cycle stalls from any stage, jump redirects from a configurable resolve stage, and prioritised interrupts/exceptions through a drain-then-flush state machine. It sits beside the datapath and feeds the pipeline-register enables and the fetch redirect mux.

## Interface
- STAGES, 5, number of pipeline stages; inter-stage registers R = STAGES-1, register i sits between stage i and i+1
- JMP_STAGE, 2, stage in which jumps resolve (1 ≤ JMP_STAGE ≤ STAGES-2)
- NINT, 3, number of interrupt/exception sources; bit n is raised by stage n (bit 0 = external INT at fetch)
- CW, clog2(NINT) (min 1), width of cause code

Ports:
- clk  in  1  clock; all state updates on falling edge
- rst  in  1  reset, synchronous, active-high
- pval  in  1  fetch output valid
- stage_busy  in  STAGES  stage s cannot accept a new instruction this cycle (multi-cycle op / memory op)
- jmp  in  2  bit0 jump taken in JMP_STAGE, bit1 kind (1 = register, 0 = immediate)
- intp  in  NINT  interrupt/exception request per source
- ctr  out  2*R  code for register i at [2i+1:2i]: 00 LOAD, 01 BUBBLE (load NOP), 10 HOLD, 11 FLUSH
- jmp_type  out  2  redirect: 00 none, 01 jmpr, 10 jmpi, 11 interrupt vector
- int_cause  out  CW  index of serviced source, valid when jmp_type = 11
- stall_cnt  out  16  stall-cycle counter (see Configuration)
- flush_cnt  out  16  flush-event counter (see Configuration)

## Operation
- States: RUN, DRAIN, FLUSH. Reset → RUN.
- RUN priority, highest first: interrupt, stall above JMP_STAGE, jump, stall at or below JMP_STAGE, pval low, normal.
- Interrupt (any intp bit in RUN): latch cause = highest set index (deepest stage = oldest instruction). Go to DRAIN if any stage_busy, else FLUSH. All ctr = HOLD this cycle.
- Stall: k = highest busy index. Regs 0..k-1 HOLD, reg k BUBBLE, regs >k LOAD. For k = 0: reg 0 BUBBLE, rest LOAD.
- Stall with k > JMP_STAGE suppresses the jump. The jump stage is held and re-presents jmp next cycle.
- Jump (jmp[0] = 1, not suppressed): regs 0..JMP_STAGE-1 FLUSH, remainder LOAD. jmp_type = {~jmp[1], jmp[1]}, for exactly one cycle.
- Jump combined with stall k ≤ JMP_STAGE: the jump wins and the younger stall is discarded by the flush.
- pval low, no other event: reg 0 BUBBLE, rest LOAD.
- Normal: all LOAD, jmp_type 00.
- DRAIN: all ctr HOLD. Remain in DRAIN until stage_busy == 0, then go to FLUSH. intp and jmp are ignored.
- FLUSH: all ctr FLUSH, jmp_type 11, int_cause = latched cause, for one cycle, then RUN. intp is ignored this cycle.
- int_cause holds its last value outside FLUSH. jmp_type is 00 in every cycle not listed above.

## Timing
- Inputs are sampled on the falling edge. Outputs are registered and valid from that edge for the following rising edge of the datapath.
- Latency from a request to its control code: 1 falling edge (same half-cycle as the original controller).
- Reset values: ctr all 00, jmp_type 00, int_cause 0, state RUN, counters 0. rst during DRAIN or FLUSH aborts to RUN with no redirect.
- An interrupt with no busy stage takes 2 cycles (HOLD, FLUSH).
- A drain with m busy cycles takes m+2 cycles.
- Back-to-back: an intp still high in the cycle after FLUSH starts a new sequence. Sources must deassert on acknowledgement (jmp_type 11 with their cause).

## Configuration
- PIPE_CTRL_PERF_EN defined:
  - stall_cnt increments on every cycle in which any ctr is HOLD (RUN stall, interrupt entry, DRAIN).
  - flush_cnt increments on each jump flush and each FLUSH state.
  - Both saturate at 0xFFFF and clear on rst.
- PIPE_CTRL_PERF_EN undefined: counter logic is absent and both outputs are constant 0.

## Test plan
- Reset, then pval = 1 with no events → ctr = all 00 (0x00 for STAGES = 5), jmp_type 00.
- stage_busy = 5'b00100 for 3 cycles → ctr = {00,01,10,10} (reg3..reg0) each cycle. With PERF, stall_cnt = 3.
- jmp = 2'b11 alone → ctr = {00,00,11,11}, jmp_type 01 for one cycle. jmp = 2'b01 → jmp_type 10.
- jmp = 2'b01 together with stage_busy[3] = 1 → stall pattern {01,10,10,10}, jmp_type 00. The jump fires the cycle after busy drops.
- intp = 3'b101 with stage_busy[3] high 2 cycles → HOLD ×3, then ctr all 11, jmp_type 11, int_cause 2, then RUN. With PERF, flush_cnt +1.
- rst asserted during DRAIN → next edge: state RUN, all outputs at reset values, no FLUSH cycle issued.
